// File: rtl/spm_pkg.sv
// spm_pkg: shared FSM state type and default parameters for the serial multiplier
package spm_pkg;
   localparam int SPM_DEFAULT_WIDTH = 8;
   localparam int SPM_DEFAULT_GUARD = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, FINAL = 2'd2} spm_state_t;
endpackage

// File: rtl/param_signed_spm_csa_row.sv
// csa_row: W-bit 3:2 carry-save row
// Ports: x, y, z - three addends; sum - bitwise sum; carry - majority shifted left one place
module csa_row #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] z,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);
   logic [W-1:0] maj;
   assign sum   = x ^ y ^ z;
   assign maj   = (x & y) | (x & z) | (y & z);
   assign carry = maj << 1;
endmodule

// File: rtl/param_signed_spm.sv
// param_signed_spm: bit-serial signed/unsigned multiplier with carry-save accumulation
// Ports: clk, rst_n (async active-low); start, signed_mode, a, b sampled in IDLE;
//        busy high in MULT/FINAL; done one-cycle pulse; product held between dones.
// Optional macro SPM_ACC_EN adds acc_clr input and acc output (running sum of products).
module param_signed_spm
   import spm_pkg::*;
#(
   parameter int WIDTH = SPM_DEFAULT_WIDTH,
   parameter int GUARD = SPM_DEFAULT_GUARD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
`ifdef SPM_ACC_EN
   ,
   input  logic                     acc_clr,
   output logic [2*WIDTH+GUARD-1:0] acc
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;
   spm_state_t state, nxt;
   logic [PW-1:0] mcand, sum, carry, csa_s, csa_c, res, fin;
   logic [WIDTH-1:0] mplier, mag_a, mag_b;
   logic [CW-1:0] count;
   logic sign, take;
   // two's-complement negate of the most negative value wraps to 2^(W-1), which is the magnitude we want
   assign mag_a = (signed_mode & a[WIDTH-1]) ? -a : a;
   assign mag_b = (signed_mode & b[WIDTH-1]) ? -b : b;
   assign take  = state == IDLE && start;
   assign busy  = state != IDLE;
   assign res   = sum + carry;
   assign fin   = sign ? -res : res;
   csa_row #(.W(PW)) u_csa (
      .x    (sum),
      .y    (carry),
      .z    (mplier[0] ? mcand : '0),
      .sum  (csa_s),
      .carry(csa_c)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end
   always_comb begin
      nxt = take ? MULT :
            (state == MULT && count != CW'(WIDTH - 1)) ? MULT :
            (state == MULT) ? FINAL : IDLE;
   end
`ifdef SPM_ACC_EN
   logic mode_q;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         sum     <= '0;
         carry   <= '0;
         count   <= '0;
         sign    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
`ifdef SPM_ACC_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         done <= state == FINAL;
         if (take) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            sum    <= '0;
            carry  <= '0;
            count  <= '0;
`ifdef SPM_ACC_EN
            mode_q <= signed_mode;
`endif
         end else if (state == MULT) begin
            // mcand tracks multiplicand << count, so the row adds the correctly weighted partial product
            sum    <= csa_s;
            carry  <= csa_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
         end else if (state == FINAL) begin
            product <= fin;
         end
      end
   end
`ifdef SPM_ACC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               acc <= '0;
      else if (state == FINAL)  acc <= (acc_clr ? '0 : acc) + {{GUARD{mode_q & fin[PW-1]}}, fin};
      else if (acc_clr)         acc <= '0;
   end
`endif
endmodule

// File: tb/tb_param_signed_spm.sv
// tb_param_signed_spm: directed self-checking bench for param_signed_spm (WIDTH 8 and 16)
module tb_param_signed_spm;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic start8 = 1'b0, sm8 = 1'b0, busy8, done8;
   logic [7:0] a8 = '0, b8 = '0;
   logic [15:0] p8;
   logic start16 = 1'b0, sm16 = 1'b0, busy16, done16;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] p16;
`ifdef SPM_ACC_EN
   logic clr8 = 1'b0, clr16 = 1'b0;
   logic [19:0] acc8;
   logic [35:0] acc16;
`endif
   int vec = 0, miss = 0, k;
   param_signed_spm #(.WIDTH(8)) d8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(p8)
`ifdef SPM_ACC_EN
      , .acc_clr(clr8), .acc(acc8)
`endif
   );
   param_signed_spm #(.WIDTH(16)) d16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .product(p16)
`ifdef SPM_ACC_EN
      , .acc_clr(clr16), .acc(acc16)
`endif
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic pulse8(input bit sm, input logic [7:0] x, input logic [7:0] y);
      sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 'x; b8 = 'x;
   endtask
   task automatic pulse16(input bit sm, input logic [15:0] x, input logic [15:0] y);
      sm16 = sm; a16 = x; b16 = y; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; a16 = 'x; b16 = 'x;
   endtask
   task automatic wait8(output int n);
      n = 0;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic wait16(output int n);
      n = 0;
      while (!done16 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask
   initial begin
      #12;
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_product", p8, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse8(1'b1, 8'h80, 8'h80);
      wait8(k);
      chk("lat_80x80", k, 9);
      chk("p_80x80", p8, 16'h4000);
      @(negedge clk);
      chk("done_one_cycle", done8, 1'b0);
      chk("product_held", p8, 16'h4000);
      pulse8(1'b1, 8'hFF, 8'h7F);
      wait8(k);
      chk("p_m1x127", p8, 16'hFF81);
      pulse8(1'b0, 8'hFF, 8'hFF);
      wait8(k);
      chk("p_uFFxFF", p8, 16'hFE01);
      pulse16(1'b1, 16'h8000, 16'h7FFF);
      wait16(k);
      chk("lat16", k, 17);
      chk("p16_min_x_max", p16, 32'hC0008000);
      pulse16(1'b1, 16'h0000, 16'h1234);
      wait16(k);
      chk("p16_zero", p16, 32'h0);
      pulse8(1'b1, 8'd7, 8'd9);
      repeat (3) @(negedge clk);
      chk("busy_mid", busy8, 1'b1);
      pulse8(1'b0, 8'd2, 8'd2);
      wait8(k);
      chk("ignored_lat", k, 5);
      chk("ignored_p", p8, 16'h003F);
      pulse8(1'b1, 8'hFE, 8'd3);
      wait8(k);
      chk("b2b_gap", k + 1, 10);
      chk("b2b_p", p8, 16'hFFFA);
      pulse8(1'b1, 8'h7F, 8'h7F);
      repeat (4) @(negedge clk);
      chk("busy_pre_rst", busy8, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy8, 1'b0);
      chk("arst_done", done8, 1'b0);
      chk("arst_product", p8, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse8(1'b0, 8'd3, 8'd5);
      wait8(k);
      chk("post_rst_lat", k, 9);
      chk("post_rst_p", p8, 16'h000F);
`ifdef SPM_ACC_EN
      clr8 = 1'b1;
      @(negedge clk);
      clr8 = 1'b0;
      chk("acc_clr", acc8, 20'h0);
      pulse8(1'b1, 8'd100, 8'd100);
      wait8(k);
      chk("acc_10000", acc8, 20'd10000);
      pulse8(1'b1, 8'hCE, 8'd2);
      wait8(k);
      chk("acc_9900", acc8, 20'd9900);
      pulse8(1'b1, 8'd3, 8'hFC);
      repeat (8) @(negedge clk);
      clr8 = 1'b1;
      @(negedge clk);
      clr8 = 1'b0;
      chk("acc_clr_final_done", done8, 1'b1);
      chk("acc_clr_final", acc8, 20'hFFFF4);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
